// File: rtl/uart_mmio_regs_pkg.sv
// uart_mmio_regs_pkg: shared UART peripheral definitions.
//   - register offsets within the UART MMIO page
//   - STATUS register bit positions
//   - uart_ctrl_t, the CTRL register layout
package uart_mmio_regs_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam int unsigned UART_TXDATA_OFF = 32'h00;
   localparam int unsigned UART_RXDATA_OFF = 32'h04;
   localparam int unsigned UART_STATUS_OFF = 32'h08;
   localparam int unsigned UART_CTRL_OFF   = 32'h0C;
   localparam int unsigned UART_BAUD_OFF   = 32'h10;

   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_RX_EMPTY   = 2;
   localparam int unsigned ST_RX_FULL    = 3;
   localparam int unsigned ST_RX_OVR     = 4;
   localparam int unsigned ST_TX_OVF     = 5;
   localparam int unsigned ST_TX_CNT_LSB = 8;
   localparam int unsigned ST_RX_CNT_LSB = 16;

   typedef struct packed {
      logic irq_tx_en;
      logic irq_rx_en;
      logic rx_en;
      logic tx_en;
   } uart_ctrl_t;

   localparam uart_ctrl_t CTRL_RST = '{irq_tx_en: 1'b0, irq_rx_en: 1'b0,
                                       rx_en: 1'b1, tx_en: 1'b1};

endpackage

// File: rtl/uart_mmio_regs_if.sv
// mmio_if: single-cycle MMIO request/response bus.
//   master drives mmio_valid/we/addr/wdata/wstrb; slave returns mmio_ready and
//   mmio_rdata (registered, one cycle after the accept).
interface mmio_if #(
   parameter int unsigned ADDR_W = 12
);
   import uart_mmio_regs_pkg::*;

   logic              mmio_valid;
   logic              mmio_we;
   logic [ADDR_W-1:0] mmio_addr;
   logic [DATA_W-1:0] mmio_wdata;
   logic [STRB_W-1:0] mmio_wstrb;
   logic              mmio_ready;
   logic [DATA_W-1:0] mmio_rdata;

   modport master (
      output mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
      input  mmio_ready, mmio_rdata
   );

   modport slave (
      input  mmio_valid, mmio_we, mmio_addr, mmio_wdata, mmio_wstrb,
      output mmio_ready, mmio_rdata
   );
endinterface

// File: rtl/uart_mmio_regs_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   push/din in, pop in, dout = head (0 when empty), full/empty/count out.
//   Push into a full FIFO and pop from an empty FIFO are ignored; full/empty
//   are the state at the start of the cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; dout is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_mmio_regs.sv
// uart_mmio_regs: MMIO register block for the UART.
//   clk, rst_n (sync, active-low); mmio (mmio_if.slave);
//   tx_data/tx_valid/tx_ready: TX byte stream to the serial core;
//   rx_data/rx_valid: RX byte strobe from the core; baud_div; irq.
//   Optional UART_MMIO_IRQ_EN enables CTRL irq bits and the irq output.
module uart_mmio_regs
   import uart_mmio_regs_pkg::*;
#(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   mmio_if.slave       mmio,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [15:0] baud_div,
   output logic        irq
);
   localparam int unsigned AW_W  = ADDR_W - 2;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_MMIO_IRQ_EN
   localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
   localparam logic [3:0] CTRL_WMASK = 4'h3;
`endif

   logic              ready_q;
   logic [DATA_W-1:0] rdata_q;
   uart_ctrl_t        ctrl_q;
   logic [15:0]       baud_q;
   logic              rx_ovr_q;
   logic              tx_ovf_q;

   logic              accept, wr_acc, rd_acc;
   logic [AW_W-1:0]   addr_word;
   logic              sel_tx, sel_rx, sel_status, sel_ctrl, sel_baud;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [CNT_W-1:0]  tx_count, rx_count;
   logic [7:0]        rx_head;
   logic [DATA_W-1:0] status_c, rd_word_c;
   logic              clr_rx_ovr, clr_tx_ovf;
   logic              unused_ok;

   assign unused_ok = ^{mmio.mmio_addr[1:0], mmio.mmio_wdata[31:16], mmio.mmio_wstrb[3:2]};

   assign mmio.mmio_ready = ready_q;
   assign mmio.mmio_rdata = rdata_q;
   assign baud_div        = baud_q;

   // Access decode on the word address.
   assign accept     = mmio.mmio_valid & ready_q;
   assign wr_acc     = accept & mmio.mmio_we;
   assign rd_acc     = accept & ~mmio.mmio_we;
   assign addr_word  = mmio.mmio_addr[ADDR_W-1:2];
   assign sel_tx     = (addr_word == AW_W'(UART_TXDATA_OFF >> 2));
   assign sel_rx     = (addr_word == AW_W'(UART_RXDATA_OFF >> 2));
   assign sel_status = (addr_word == AW_W'(UART_STATUS_OFF >> 2));
   assign sel_ctrl   = (addr_word == AW_W'(UART_CTRL_OFF >> 2));
   assign sel_baud   = (addr_word == AW_W'(UART_BAUD_OFF >> 2));

   // FIFO control: TX fed by MMIO, drained by the core; RX the reverse.
   assign tx_push  = wr_acc & sel_tx & mmio.mmio_wstrb[0];
   assign tx_valid = ctrl_q.tx_en & ~tx_empty;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_push  = rx_valid & ctrl_q.rx_en;
   assign rx_pop   = rd_acc & sel_rx & ~rx_empty;

   assign clr_rx_ovr = wr_acc & sel_status & mmio.mmio_wstrb[0] & mmio.mmio_wdata[ST_RX_OVR];
   assign clr_tx_ovf = wr_acc & sel_status & mmio.mmio_wstrb[0] & mmio.mmio_wdata[ST_TX_OVF];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .din   (mmio.mmio_wdata[7:0]),
      .pop   (tx_pop),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .din   (rx_data),
      .pop   (rx_pop),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // STATUS word and read-data mux.
   always_comb begin
      status_c                          = '0;
      status_c[ST_TX_FULL]              = tx_full;
      status_c[ST_TX_EMPTY]             = tx_empty;
      status_c[ST_RX_EMPTY]             = rx_empty;
      status_c[ST_RX_FULL]              = rx_full;
      status_c[ST_RX_OVR]               = rx_ovr_q;
      status_c[ST_TX_OVF]               = tx_ovf_q;
      status_c[ST_TX_CNT_LSB +: 8]      = 8'(tx_count);
      status_c[ST_RX_CNT_LSB +: 8]      = 8'(rx_count);

      rd_word_c = '0;
      if (sel_rx)          rd_word_c = rx_empty ? 32'h8000_0000 : {24'b0, rx_head};
      else if (sel_status) rd_word_c = status_c;
      else if (sel_ctrl)   rd_word_c = 32'(ctrl_q);
      else if (sel_baud)   rd_word_c = {16'b0, baud_q};
   end

   // Registers; a sticky set wins over a same-cycle W1C.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         ctrl_q   <= CTRL_RST;
         baud_q   <= BAUD_DIV_RST;
         rx_ovr_q <= 1'b0;
         tx_ovf_q <= 1'b0;
      end else begin
         ready_q  <= 1'b1;
         if (rd_acc) rdata_q <= rd_word_c;
         if (wr_acc && sel_ctrl && mmio.mmio_wstrb[0])
            ctrl_q <= uart_ctrl_t'((4'(ctrl_q) & ~CTRL_WMASK) | (mmio.mmio_wdata[3:0] & CTRL_WMASK));
         if (wr_acc && sel_baud && mmio.mmio_wstrb[0]) baud_q[7:0]  <= mmio.mmio_wdata[7:0];
         if (wr_acc && sel_baud && mmio.mmio_wstrb[1]) baud_q[15:8] <= mmio.mmio_wdata[15:8];
         rx_ovr_q <= (rx_ovr_q & ~clr_rx_ovr) | (rx_push & rx_full);
         tx_ovf_q <= (tx_ovf_q & ~clr_tx_ovf) | (tx_push & tx_full);
      end
   end

`ifdef UART_MMIO_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= (ctrl_q.irq_rx_en & ~rx_empty) | (ctrl_q.irq_tx_en & tx_empty);
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_regs.sv
// tb_uart_mmio_regs: self-checking bench for uart_mmio_regs.
//   Table of register vectors plus hand-written FIFO/flag sequences; read
//   expectations are queued when a read is issued and compared when the
//   registered response appears.
module tb_uart_mmio_regs;
   localparam logic [11:0] A_TX   = 12'h000;
   localparam logic [11:0] A_RX   = 12'h004;
   localparam logic [11:0] A_ST   = 12'h008;
   localparam logic [11:0] A_CTRL = 12'h00C;
   localparam logic [11:0] A_BAUD = 12'h010;
`ifdef UART_MMIO_IRQ_EN
   localparam logic [31:0] CTRL7_RB = 32'h7;
`else
   localparam logic [31:0] CTRL7_RB = 32'h3;
`endif

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      string       nm;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [15:0] baud_div;
   logic        irq;

   int   pass_cnt = 0;
   int   chk_cnt  = 0;
   sb_t  sb[$];
   vec_t vecs[$];
   logic rd_pend = 1'b0;

   mmio_if #(.ADDR_W(12)) bus ();

   uart_mmio_regs #(.ADDR_W(12), .FIFO_DEPTH(16), .BAUD_DIV_RST(16'd434)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mmio     (bus.slave),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .baud_div (baud_div),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endfunction

   // Response checker: one cycle after a read accept, compare against the queue head.
   always @(posedge clk) rd_pend <= bus.mmio_valid & bus.mmio_ready & ~bus.mmio_we;

   always @(negedge clk) begin
      if (rd_pend) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check(e.nm, bus.mmio_rdata, e.exp);
         end
      end
   end

   // One access; entered and left on a negedge.
   task automatic access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp, input string nm);
      int n = 0;
      while (!bus.mmio_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (n == 16) check({nm, "_ready_timeout"}, 32'(bus.mmio_ready), 32'd1);
      bus.mmio_valid = 1'b1;
      bus.mmio_we    = we;
      bus.mmio_addr  = addr;
      bus.mmio_wdata = wd;
      bus.mmio_wstrb = st;
      if (!we) sb.push_back('{exp: exp, nm: nm});
      @(negedge clk);
      bus.mmio_valid = 1'b0;
      bus.mmio_we    = 1'b0;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] st);
      access(1'b1, addr, wd, st, 32'h0, "wr");
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string nm);
      access(1'b0, addr, 32'h0, 4'h0, exp, nm);
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
      bus.mmio_valid = 1'b0; bus.mmio_we = 1'b0; bus.mmio_addr = '0;
      bus.mmio_wdata = '0; bus.mmio_wstrb = '0;

      vecs.push_back('{1'b0, A_ST,    32'h0,         4'h0, 32'h0000_0006, "rst_status"});
      vecs.push_back('{1'b0, A_CTRL,  32'h0,         4'h0, 32'h0000_0003, "rst_ctrl"});
      vecs.push_back('{1'b0, A_BAUD,  32'h0,         4'h0, 32'h0000_01B2, "rst_baud"});
      vecs.push_back('{1'b0, 12'h020, 32'h0,         4'h0, 32'h0000_0000, "unmapped_rd"});
      vecs.push_back('{1'b0, A_TX,    32'h0,         4'h0, 32'h0000_0000, "txdata_rd"});
      vecs.push_back('{1'b0, A_RX,    32'h0,         4'h0, 32'h8000_0000, "rx_empty_rd"});
      vecs.push_back('{1'b1, A_BAUD,  32'h0000_12FF, 4'h1, 32'h0,         "w"});
      vecs.push_back('{1'b0, A_BAUD,  32'h0,         4'h0, 32'h0000_01FF, "baud_strb0"});
      vecs.push_back('{1'b1, A_BAUD,  32'hABCD_5600, 4'h2, 32'h0,         "w"});
      vecs.push_back('{1'b0, A_BAUD,  32'h0,         4'h0, 32'h0000_56FF, "baud_strb1"});
      vecs.push_back('{1'b1, A_CTRL,  32'hFFFF_FFF3, 4'hF, 32'h0,         "w"});
      vecs.push_back('{1'b0, A_CTRL,  32'h0,         4'h0, 32'h0000_0003, "ctrl_mask"});
      vecs.push_back('{1'b1, A_CTRL,  32'h0,         4'h0, 32'h0,         "w"});
      vecs.push_back('{1'b0, A_CTRL,  32'h0,         4'h0, 32'h0000_0003, "ctrl_nostrb"});
      vecs.push_back('{1'b1, 12'h024, 32'hFFFF_FFFF, 4'hF, 32'h0,         "w"});
      vecs.push_back('{1'b1, A_TX,    32'h0000_0099, 4'hE, 32'h0,         "w"});
      vecs.push_back('{1'b0, 12'h00A, 32'h0,         4'h0, 32'h0000_0006, "addr_lsb_ign"});

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ready",    32'(bus.mmio_ready), 32'd0);
      check("rst_rdata",    bus.mmio_rdata, 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data",  32'(tx_data), 32'd0);
      check("rst_irq",      32'(irq), 32'd0);
      check("rst_baud_div", 32'(baud_div), 32'd434);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.mmio_ready), 32'd1);

      foreach (vecs[i]) access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                               vecs[i].exp, vecs[i].nm);
      check("baud_div_port", 32'(baud_div), 32'h56FF);
      wr(12'h024, 32'h1234_5678, 4'hF);
      check("rdata_hold", bus.mmio_rdata, 32'h0000_0006);

      // TX: two bytes with the core stalled, then drain.
      wr(A_TX, 32'h41, 4'h1);
      wr(A_TX, 32'h42, 4'h1);
      rd(A_ST, 32'h0000_0204, "tx_count2");
      check("tx_head0",  32'(tx_data), 32'h41);
      check("tx_valid0", 32'(tx_valid), 32'd1);
      tx_ready = 1'b1;
      @(negedge clk);
      check("tx_head1", 32'(tx_data), 32'h42);
      @(negedge clk);
      check("tx_drained", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      // TX overflow with tx_en off; W1C honours the lane strobe.
      wr(A_CTRL, 32'h2, 4'h1);
      for (int i = 0; i < 17; i++) wr(A_TX, 32'(8'h10 + 8'(i)), 4'h1);
      check("tx_en_off", 32'(tx_valid), 32'd0);
      rd(A_ST, 32'h0000_1025, "tx_full_ovf");
      wr(A_ST, 32'h0000_3030, 4'h2);
      rd(A_ST, 32'h0000_1025, "w1c_wrong_lane");
      wr(A_ST, 32'h20, 4'h1);
      rd(A_ST, 32'h0000_1005, "tx_ovf_clr");
      tx_ready = 1'b1;
      wr(A_CTRL, 32'h3, 4'h1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("tx_drain%0d", i), 32'(tx_data), 32'(8'h10 + 8'(i)));
         @(negedge clk);
      end
      check("tx_empty_end", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      // RX single byte, then empty read.
      rx_push(8'h5A);
      rd(A_RX, 32'h0000_005A, "rx_byte");
      rd(A_RX, 32'h8000_0000, "rx_empty_after");

      // rx_en off drops bytes silently.
      wr(A_CTRL, 32'h1, 4'h1);
      rx_push(8'h77);
      rd(A_ST, 32'h0000_0006, "rx_en_off");
      wr(A_CTRL, 32'h3, 4'h1);

      // RX overflow, set-vs-clear, push on full with pop.
      for (int i = 0; i < 17; i++) rx_push(i == 16 ? 8'hEE : 8'(8'hA0 + 8'(i)));
      rd(A_ST, 32'h0010_001A, "rx_full_ovr");
      wr(A_ST, 32'h10, 4'h1);
      rd(A_ST, 32'h0010_000A, "rx_ovr_clr");
      rx_valid = 1'b1; rx_data = 8'hEF;
      wr(A_ST, 32'h10, 4'h1);
      rx_valid = 1'b0;
      rd(A_ST, 32'h0010_001A, "set_wins");
      wr(A_ST, 32'h10, 4'h1);
      rx_valid = 1'b1; rx_data = 8'hF0;
      rd(A_RX, 32'h0000_00A0, "full_pop_head");
      rx_valid = 1'b0;
      rd(A_ST, 32'h000F_0012, "full_push_dropped");
      wr(A_ST, 32'h10, 4'h1);
      for (int i = 1; i < 16; i++) rd(A_RX, 32'(8'hA0 + 8'(i)), $sformatf("rx_drain%0d", i));
      rd(A_RX, 32'h8000_0000, "rx_drained");

      // Simultaneous push and pop keeps the count.
      rx_push(8'h11);
      rx_valid = 1'b1; rx_data = 8'h22;
      rd(A_RX, 32'h0000_0011, "pp_pop");
      rx_valid = 1'b0;
      rd(A_ST, 32'h0001_0002, "pp_count");
      rd(A_RX, 32'h0000_0022, "pp_new");

      // Interrupt.
      wr(A_CTRL, 32'h7, 4'h1);
      rd(A_CTRL, CTRL7_RB, "ctrl7");
      check("irq_idle", 32'(irq), 32'd0);
      rx_push(8'h33);
      check("irq_lat", 32'(irq), 32'd0);
      @(negedge clk);
`ifdef UART_MMIO_IRQ_EN
      check("irq_rise", 32'(irq), 32'd1);
`else
      check("irq_tied", 32'(irq), 32'd0);
`endif
      rd(A_RX, 32'h0000_0033, "irq_rx_read");
      @(negedge clk);
      check("irq_fall", 32'(irq), 32'd0);
      wr(A_CTRL, 32'h3, 4'h1);

      // Reset mid-operation flushes everything.
      wr(A_TX, 32'h77, 4'h1);
      rx_push(8'h55);
      check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ready",    32'(bus.mmio_ready), 32'd0);
      check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      check("mid_rst_rdata",    bus.mmio_rdata, 32'd0);
      check("mid_rst_baud",     32'(baud_div), 32'd434);
      rst_n = 1'b1;
      rd(A_ST, 32'h0000_0006, "post_rst_status");
      rd(A_CTRL, 32'h0000_0003, "post_rst_ctrl");

      repeat (2) @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/uart_mmio_regs.md
# uart_mmio_regs

Peripheral-side MMIO responder for the UART: terminates the `mmio_if` slave port driven by the SoC interconnect and exposes TX/RX byte FIFOs, status, control and baud-divisor registers. It sits between the interconnect's UART page and the UART serial core, which it feeds through byte-wide valid/ready streams. It returns read data on the cycle after the interconnect accepts an access, matching the interconnect's fixed one-cycle MMIO response.

## Interface

Parameters:
- ADDR_W, 12, MMIO offset width (4 KB page).
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥2.
- BAUD_DIV_RST, 16'd434, BAUD_DIV reset value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- mmio  mmio_if.slave  —  mmio_valid, mmio_we, mmio_addr[ADDR_W-1:0], mmio_wdata[31:0], mmio_wstrb[3:0] in; mmio_ready, mmio_rdata[31:0] out.
- tx_data  out  8  TX FIFO head byte.
- tx_valid  out  1  TX byte available.
- tx_ready  in  1  core consumed TX byte.
- rx_data  in  8  received byte.
- rx_valid  in  1  received byte strobe; single-cycle, no backpressure.
- baud_div  out  16  BAUD_DIV register.
- irq  out  1  level interrupt.

## Operation

- Accept condition: mmio_valid & mmio_ready. Decode uses mmio_addr[ADDR_W-1:2]; mmio_addr[1:0] is ignored.
- Unmapped offsets: reads return 0, writes are ignored.
- Writes honour mmio_wstrb per byte lane.

Register map:
- 0x00 TXDATA, WO. A write with wstrb[0] pushes wdata[7:0]. If the FIFO is full, the byte is dropped and STATUS.tx_ovf is set. Reads return 0.
- 0x04 RXDATA, RO. If the FIFO is not empty, the read returns {24'b0, head} and pops. If empty, it returns 32'h8000_0000 and does not pop.
- 0x08 STATUS:
  - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
  - bit4 rx_ovr, sticky, W1C.
  - bit5 tx_ovf, sticky, W1C.
  - [15:8] tx_count, [23:16] rx_count, zero-extended.
- 0x0C CTRL, RW:
  - bit0 tx_en, bit1 rx_en, bit2 irq_rx_en, bit3 irq_tx_en; other bits read 0.
- 0x10 BAUD_DIV, RW, [15:0]; drives baud_div.

TX side:
- tx_valid = tx_en & ~tx_empty; tx_data = FIFO head.
- The FIFO pops on tx_valid & tx_ready.

RX side:
- rx_valid & rx_en pushes rx_data.
- If the FIFO is full, the byte is dropped and rx_ovr is set.
- When rx_en = 0, incoming bytes are ignored and no flag is set.

Boundary rules:
- Full/empty is evaluated on the state at the start of the cycle. A push into a full FIFO is dropped even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- If a sticky flag is being set and W1C-cleared in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH. Counts are $clog2(FIFO_DEPTH)+1 bits.

## Timing

- mmio_ready is 0 in reset and 1 from the first cycle after reset. No wait states.
- mmio_rdata is registered on a read accept, valid the next cycle, and held until the next accepted read. Write accepts do not change it.
- Register writes, FIFO pops and flag updates take effect at the accept edge. STATUS read in the next access reflects them.
- tx_valid reflects a push in the cycle after the TXDATA write.
- Reset values:
  - mmio_rdata 0, tx_valid 0, tx_data 0, irq 0.
  - CTRL 0x3, BAUD_DIV BAUD_DIV_RST, flags 0, both FIFOs empty.
- Reset mid-operation flushes both FIFOs. An in-flight TX byte already handed to the core is the core's concern.

## Configuration

- UART_MMIO_IRQ_EN defined: CTRL bits 2–3 are implemented and irq = (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty), registered for one cycle of latency.
- UART_MMIO_IRQ_EN undefined: CTRL bits 2–3 read 0 and ignore writes; irq is tied 0. The port list is unchanged.

## Structure

- Shared periph package holds:
  - offset constants UART_TXDATA_OFF, UART_RXDATA_OFF, UART_STATUS_OFF, UART_CTRL_OFF, UART_BAUD_OFF;
  - STATUS bit-index constants;
  - packed struct uart_ctrl_t.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; outputs full, empty, count), instantiated twice, WIDTH = 8.

## Test plan

- Reset, then read STATUS and CTRL → 0x0000_0006 and 0x0000_0003; baud_div = 434, tx_valid = 0.
- Write TXDATA 0x41, 0x42 with tx_ready held low → STATUS tx_count = 2. Raise tx_ready → tx_data 0x41 then 0x42, then tx_valid drops.
- Drive rx_valid with 0x5A, then read RXDATA twice → 0x0000_005A, then 0x8000_0000.
- Push 17 RX bytes (depth 16) → rx_full = 1 and rx_ovr = 1. Write STATUS 0x10 → rx_ovr = 0 and all 16 bytes are intact.
- Write BAUD_DIV with wstrb 4'b0001, data 0x0000_12FF, from reset → baud_div = 0x01FF.
- With UART_MMIO_IRQ_EN: set CTRL = 0x7, push one RX byte → irq rises next cycle and falls after the RXDATA read.
